class_vec_stream_ctrl: RTL and testbench
========================================

// Module: class_vec_stream_ctrl
// PURPOSE
//  Sequences the class hypervector ROM (class_vec_gen: frame_id x frame_index -> FRAME_W-bit frame).
//  On start, walks all classes (or one selected class) frame by frame and streams registered
//  frames over a valid/ready port to the downstream similarity/Hamming-distance unit.
//  Sits between the inference controller (start/done) and the associative-search datapath.
// PARAMETERS
//  N_CLASSES  10   number of classes stored in the ROM
//  N_FRAMES   3    frames per class hypervector (D = N_FRAMES*FRAME_W)
//  FRAME_W    100  bits per ROM frame
//  CID_W      4    width of class id, >= clog2(N_CLASSES)
//  FIDX_W     2    width of frame index, >= clog2(N_FRAMES)
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  start          in   1        1-cycle request; sampled only in IDLE
//  single_mode    in   1        1: stream only class_sel; 0: stream classes 0..N_CLASSES-1
//  class_sel      in   CID_W    class for single_mode, sampled with start
//  abort          in   1        cancel current walk
//  busy           out  1        high from accepted start until done/abort/error
//  done           out  1        1-cycle pulse after last frame handshake
//  err_sel        out  1        1-cycle pulse: single_mode start with class_sel >= N_CLASSES
//  rom_frame_id   out  CID_W    to class_vec_gen.frame_id
//  rom_frame_idx  out  FIDX_W   to class_vec_gen.frame_index
//  rom_vec        in   FRAME_W  from class_vec_gen.class_vec_out (combinational)
//  m_valid        out  1        output frame valid
//  m_ready        in   1        downstream accept
//  m_data         out  FRAME_W  frame payload
//  m_class_id     out  CID_W    class of m_data
//  m_frame_idx    out  FIDX_W   frame index of m_data
//  m_last_frame   out  1        m_frame_idx == N_FRAMES-1
//  m_last_class   out  1        final class of this walk (with m_last_frame => last beat)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err_sel, m_valid, m_last_* = 0; m_data, m_class_id, m_frame_idx,
//   rom_frame_id, rom_frame_idx = 0.
//  FSM IDLE -> RUN -> DRAIN -> IDLE (done pulse on exit of DRAIN).
//  IDLE: start & valid sel -> RUN, addr = {first class, 0}, busy=1 next cycle.
//   start & single_mode & class_sel>=N_CLASSES -> err_sel pulse next cycle, stay IDLE, busy=0.
//  RUN: address counter is valid; load = (!m_valid | m_ready). On load: m_data<=rom_vec, tags<=addr,
//   m_valid<=1, addr advances (frame_idx wraps N_FRAMES-1 -> 0 with class_id+1). Loading final addr -> DRAIN.
//  DRAIN: m_valid held; on m_valid&m_ready -> IDLE, m_valid<=0, busy<=0, done pulse same edge.
//  Latency: start at edge t -> first m_valid at t+2; with m_ready tied high, 1 frame/cycle,
//   total N_CLASSES*N_FRAMES beats (3 in single_mode); done asserted cycle after last beat accepted.
//  Backpressure: m_valid & !m_ready -> m_data and all m_* tags stable; addr does not advance.
//  m_valid never deasserts without handshake except abort/reset.
//  start while busy: ignored, no effect on walk. start & abort same cycle in IDLE: abort wins.
//  abort (any non-IDLE state): next edge IDLE, m_valid=0, busy=0, no done; in-flight beat dropped.
//  rom_* outputs are the registered address; ROM path rom_* -> rom_vec -> m_data is one cycle.
//  Counter wrap: class_id stops at N_CLASSES-1 (never drives out-of-range ROM address).
//  Reset mid-walk: immediate return to reset values; no done, no partial beat retained.
// STRUCTURE
//  Shared package hdc_ctrl_pkg: N_CLASSES, N_FRAMES, FRAME_W, CID_W, FIDX_W defaults and
//   localparam state encoding (ST_IDLE, ST_RUN, ST_DRAIN).
//  Sub-module cv_addr_cnt: nested class/frame counter with load(first,last class), advance,
//   is_last outputs. class_vec_gen instantiated at top level, not inside this block.
// TESTING
//  1 start, single_mode=0, m_ready=1 -> 30 beats consecutive, tags (0,0)..(9,2), m_data == ROM,
//    last beat m_last_frame=m_last_class=1, done at last beat+1, busy low same edge.
//  2 start, single_mode=1, class_sel=4 -> 3 beats class 4 idx 0,1,2; frame 0 = ROM[4][0]; done.
//  3 full walk, m_ready random 50% -> m_* stable while stalled, 30 beats in order, no dup/loss.
//  4 abort asserted after 7th handshake -> m_valid=0 next cycle, busy=0, no done; fresh start walks from (0,0).
//  5 single_mode=1, class_sel=12 -> err_sel one pulse, busy stays 0, no m_valid.
//  6 rst asserted mid-walk (m_valid=1, m_ready=0) -> all outputs to reset values asynchronously;
//    start while busy -> ignored, beat count unchanged.

Source files
------------

// File: rtl/hdc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdc_ctrl_pkg
// Purpose  : Shared sizes and controller state encoding for the class-vector streamer.
// Revision : 1.0
// ============================================================================
package hdc_ctrl_pkg;

    localparam int N_CLASSES = 10;
    localparam int N_FRAMES  = 3;
    localparam int FRAME_W   = 100;
    localparam int CID_W     = 4;
    localparam int FIDX_W    = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } state_e;

endpackage
`default_nettype wire

// File: rtl/class_vec_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : class_vec_stream_ctrl_if
// Purpose  : Valid/ready frame stream towards the similarity unit.
// Revision : 1.0
// ============================================================================
interface class_vec_stream_ctrl_if #(
    parameter int FRAME_W = hdc_ctrl_pkg::FRAME_W,
    parameter int CID_W   = hdc_ctrl_pkg::CID_W,
    parameter int FIDX_W  = hdc_ctrl_pkg::FIDX_W
) ();
    import hdc_ctrl_pkg::*;

    logic               m_valid;
    logic               m_ready;
    logic [FRAME_W-1:0] m_data;
    logic [CID_W-1:0]   m_class_id;
    logic [FIDX_W-1:0]  m_frame_idx;
    logic               m_last_frame;
    logic               m_last_class;

    modport master (
        output m_valid, m_data, m_class_id, m_frame_idx, m_last_frame, m_last_class,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_class_id, m_frame_idx, m_last_frame, m_last_class,
        output m_ready
    );

endinterface
`default_nettype wire

// File: rtl/cv_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cv_addr_cnt
// Purpose  : Nested class/frame address counter for the class ROM walk.
// Revision : 1.0
// ============================================================================
module cv_addr_cnt #(
    parameter int N_CLASSES = hdc_ctrl_pkg::N_CLASSES,
    parameter int N_FRAMES  = hdc_ctrl_pkg::N_FRAMES,
    parameter int CID_W     = hdc_ctrl_pkg::CID_W,
    parameter int FIDX_W    = hdc_ctrl_pkg::FIDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CID_W-1:0]  first_cid,
    input  logic [CID_W-1:0]  last_cid,
    input  logic              advance,
    output logic [CID_W-1:0]  cid,
    output logic [FIDX_W-1:0] fidx,
    output logic              last_frame,
    output logic              last_class,
    output logic              is_last
);
    import hdc_ctrl_pkg::*;

    localparam logic [CID_W-1:0]  CID_MAX  = CID_W'(N_CLASSES - 1);
    localparam logic [FIDX_W-1:0] FIDX_MAX = FIDX_W'(N_FRAMES - 1);

    logic [CID_W-1:0]  cid_q, cid_d;
    logic [CID_W-1:0]  last_cid_q, last_cid_d;
    logic [FIDX_W-1:0] fidx_q, fidx_d;

    always_comb begin
        cid_d      = cid_q;
        fidx_d     = fidx_q;
        last_cid_d = last_cid_q;
        if (load) begin
            cid_d      = first_cid;
            fidx_d     = '0;
            last_cid_d = last_cid;
        end else if (advance) begin
            if (fidx_q == FIDX_MAX) begin
                fidx_d = '0;
                // Saturate so the ROM never sees an out-of-range class id.
                if (cid_q != CID_MAX) begin
                    cid_d = cid_q + CID_W'(1);
                end
            end else begin
                fidx_d = fidx_q + FIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cid_q      <= '0;
            fidx_q     <= '0;
            last_cid_q <= '0;
        end else begin
            cid_q      <= cid_d;
            fidx_q     <= fidx_d;
            last_cid_q <= last_cid_d;
        end
    end

    assign cid        = cid_q;
    assign fidx       = fidx_q;
    assign last_frame = (fidx_q == FIDX_MAX);
    assign last_class = (cid_q == last_cid_q);
    assign is_last    = last_frame && last_class;

endmodule
`default_nettype wire

// File: rtl/class_vec_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : class_vec_stream_ctrl
// Purpose  : Walks the class hypervector ROM and streams registered frames downstream.
// Revision : 1.0
// ============================================================================
module class_vec_stream_ctrl #(
    parameter int N_CLASSES = hdc_ctrl_pkg::N_CLASSES,
    parameter int N_FRAMES  = hdc_ctrl_pkg::N_FRAMES,
    parameter int FRAME_W   = hdc_ctrl_pkg::FRAME_W,
    parameter int CID_W     = hdc_ctrl_pkg::CID_W,
    parameter int FIDX_W    = hdc_ctrl_pkg::FIDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     single_mode,
    input  logic [CID_W-1:0]         class_sel,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err_sel,
    output logic [CID_W-1:0]         rom_frame_id,
    output logic [FIDX_W-1:0]        rom_frame_idx,
    input  logic [FRAME_W-1:0]       rom_vec,
    class_vec_stream_ctrl_if.master  m
);
    import hdc_ctrl_pkg::*;

    localparam logic [CID_W-1:0] CID_MAX = CID_W'(N_CLASSES - 1);

    state_e             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               valid_q, valid_d, lf_q, lf_d, lc_q, lc_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic [CID_W-1:0]   tcid_q, tcid_d;
    logic [FIDX_W-1:0]  tfidx_q, tfidx_d;

    logic              cnt_load, cnt_adv, cnt_lf, cnt_lc, cnt_last;
    logic [CID_W-1:0]  cnt_cid, first_cid, last_cid;
    logic [FIDX_W-1:0] cnt_fidx;
    logic              sel_ok, load_beat;

    assign sel_ok    = !single_mode || ({1'b0, class_sel} < (CID_W+1)'(N_CLASSES));
    assign first_cid = single_mode ? class_sel : '0;
    assign last_cid  = single_mode ? class_sel : CID_MAX;
    assign load_beat = !valid_q || m.m_ready;

    cv_addr_cnt #(
        .N_CLASSES (N_CLASSES),
        .N_FRAMES  (N_FRAMES),
        .CID_W     (CID_W),
        .FIDX_W    (FIDX_W)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .first_cid  (first_cid),
        .last_cid   (last_cid),
        .advance    (cnt_adv),
        .cid        (cnt_cid),
        .fidx       (cnt_fidx),
        .last_frame (cnt_lf),
        .last_class (cnt_lc),
        .is_last    (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        valid_d  = valid_q;
        data_d   = data_q;
        tcid_d   = tcid_q;
        tfidx_d  = tfidx_q;
        lf_d     = lf_q;
        lc_d     = lc_q;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (sel_ok) begin
                        cnt_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    lf_d    = 1'b0;
                    lc_d    = 1'b0;
                end else if (load_beat) begin
                    valid_d = 1'b1;
                    data_d  = rom_vec;
                    tcid_d  = cnt_cid;
                    tfidx_d = cnt_fidx;
                    lf_d    = cnt_lf;
                    lc_d    = cnt_lc;
                    if (cnt_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (abort || (valid_q && m.m_ready)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    lf_d    = 1'b0;
                    lc_d    = 1'b0;
                    done_d  = !abort;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tcid_q  <= '0;
            tfidx_q <= '0;
            lf_q    <= 1'b0;
            lc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tcid_q  <= tcid_d;
            tfidx_q <= tfidx_d;
            lf_q    <= lf_d;
            lc_q    <= lc_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_sel        = err_q;
    assign rom_frame_id   = cnt_cid;
    assign rom_frame_idx  = cnt_fidx;
    assign m.m_valid      = valid_q;
    assign m.m_data       = data_q;
    assign m.m_class_id   = tcid_q;
    assign m.m_frame_idx  = tfidx_q;
    assign m.m_last_frame = lf_q;
    assign m.m_last_class = lc_q;

endmodule
`default_nettype wire

// File: tb/tb_class_vec_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_class_vec_stream_ctrl
// Purpose  : Randomised-backpressure bench with a queue-based model of the ROM walk.
// Revision : 1.0
// ============================================================================
module tb_class_vec_stream_ctrl;
    import hdc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] cid;
        logic [1:0] fidx;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               single_mode = 1'b0;
    logic [CID_W-1:0]   class_sel = '0;
    logic               abort = 1'b0;
    logic               busy, done, err_sel;
    logic [CID_W-1:0]   rom_frame_id;
    logic [FIDX_W-1:0]  rom_frame_idx;
    logic [FRAME_W-1:0] rom_vec;

    class_vec_stream_ctrl_if #(.FRAME_W(FRAME_W), .CID_W(CID_W), .FIDX_W(FIDX_W)) sif ();

    class_vec_stream_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .single_mode   (single_mode),
        .class_sel     (class_sel),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .err_sel       (err_sel),
        .rom_frame_id  (rom_frame_id),
        .rom_frame_idx (rom_frame_idx),
        .rom_vec       (rom_vec),
        .m             (sif)
    );

    always #5 clk = ~clk;

    // Stand-in for class_vec_gen: a fixed pseudo-random frame per address.
    function automatic logic [99:0] rom_f(input logic [3:0] c, input logic [1:0] f);
        logic [31:0] s;
        s = ({26'd0, c, f} + 32'd1) * 32'h9E3779B1;
        return {s[3:0], s, ~s, s ^ 32'hA5A5A5A5};
    endfunction

    assign rom_vec = rom_f(rom_frame_id, rom_frame_idx);

    int    n_checks = 0;
    int    n_pass = 0;
    int    ready_pct = 100;
    int    beats_walk = 0;
    int    n_done = 0;
    int    walk_last_cid = 0;
    beat_t exp_q[$];
    beat_t first_b, last_b;
    logic  last_lf, last_lc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic plan_walk(input bit single, input int sel);
        int lo, hi;
        exp_q.delete();
        lo = single ? sel : 0;
        hi = single ? sel : N_CLASSES - 1;
        for (int c = lo; c <= hi; c++)
            for (int f = 0; f < N_FRAMES; f++)
                exp_q.push_back('{cid: 4'(c), fidx: 2'(f)});
        walk_last_cid = hi;
        beats_walk = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sm, input int sel);
        start = 1'b1;
        single_mode = sm;
        class_sel = 4'(sel);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk(nm, seen, 1'b1);
        tick();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk(nm, {busy, done, err_sel, sif.m_valid, sif.m_last_frame, sif.m_last_class,
                 sif.m_class_id, sif.m_frame_idx, rom_frame_id, rom_frame_idx}, '0);
        chk({nm, "_data"}, sif.m_data, '0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            sif.m_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Compare process: every cycle out of reset, check the stream against the model queue.
    initial begin : compare
        logic               prev_stall;
        logic               exp_done;
        logic [FRAME_W-1:0] pd;
        logic [3:0]         pc;
        logic [1:0]         pf;
        beat_t              b;
        prev_stall = 1'b0;
        exp_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                exp_done   = 1'b0;
            end else begin
                chk("done_pulse", done, exp_done);
                exp_done = 1'b0;
                if (done) begin
                    n_done++;
                    chk("busy_low_at_done", busy, 1'b0);
                end
                if (prev_stall)
                    chk("stall_stable", {sif.m_valid, sif.m_data, sif.m_class_id, sif.m_frame_idx},
                        {1'b1, pd, pc, pf});
                if (sif.m_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        b = exp_q[0];
                        chk("beat_tags", {sif.m_class_id, sif.m_frame_idx}, {b.cid, b.fidx});
                        chk("beat_data", sif.m_data, rom_f(b.cid, b.fidx));
                        chk("beat_last_flags", {sif.m_last_frame, sif.m_last_class},
                            {(int'(b.fidx) == N_FRAMES - 1), (int'(b.cid) == walk_last_cid)});
                        if (sif.m_ready && !abort) begin
                            if (beats_walk == 0) first_b = b;
                            last_b  = b;
                            last_lf = sif.m_last_frame;
                            last_lc = sif.m_last_class;
                            void'(exp_q.pop_front());
                            beats_walk++;
                            if (exp_q.size() == 0) exp_done = 1'b1;
                        end
                    end
                end
                prev_stall = sif.m_valid && !sif.m_ready && !abort;
                pd = sif.m_data;
                pc = sif.m_class_id;
                pf = sif.m_frame_idx;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nd;
        sif.m_ready = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset_state");
        rst = 1'b0;
        tick();

        // Full walk, no backpressure
        ready_pct = 100;
        plan_walk(0, 0);
        nd = n_done;
        pulse_start(0, 0);
        chk("busy_after_start", busy, 1'b1);
        @(negedge clk);
        chk("valid_not_yet", sif.m_valid, 1'b0);
        @(negedge clk);
        chk("first_valid_latency", {sif.m_valid, sif.m_class_id, sif.m_frame_idx}, {1'b1, 4'd0, 2'd0});
        wait_done(100, "t1_done_seen");
        chk("t1_beats", beats_walk, 30);
        chk("t1_last_beat", {last_b.cid, last_b.fidx, last_lf, last_lc}, {4'd9, 2'd2, 1'b1, 1'b1});
        chk("t1_done_count", n_done - nd, 1);

        // Single class 4
        plan_walk(1, 4);
        pulse_start(1, 4);
        wait_done(50, "t2_done_seen");
        chk("t2_beats", beats_walk, 3);
        chk("t2_first_beat", {first_b.cid, first_b.fidx}, {4'd4, 2'd0});
        chk("t2_last_beat", {last_b.cid, last_b.fidx, last_lf, last_lc}, {4'd4, 2'd2, 1'b1, 1'b1});

        // Random backpressure
        ready_pct = 50;
        plan_walk(0, 0);
        pulse_start(0, 0);
        wait_done(500, "t3_done_seen");
        chk("t3_beats", beats_walk, 30);

        // Abort after 7th handshake
        ready_pct = 100;
        plan_walk(0, 0);
        nd = n_done;
        pulse_start(0, 0);
        for (int k = 0; k < 100 && beats_walk < 7; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("t4_abort_idle", {sif.m_valid, busy}, 2'b00);
        repeat (5) tick();
        chk("t4_no_done", n_done - nd, 0);
        plan_walk(0, 0);
        pulse_start(0, 0);
        wait_done(100, "t4_restart_done");
        chk("t4_restart_first", {first_b.cid, first_b.fidx}, {4'd0, 2'd0});
        chk("t4_restart_beats", beats_walk, 30);

        // Illegal class select
        pulse_start(1, 12);
        chk("t5_err_pulse", {err_sel, busy}, 2'b10);
        tick();
        chk("t5_err_one_cycle", {err_sel, busy, sif.m_valid}, 3'b000);
        repeat (3) tick();
        chk("t5_stays_idle", {busy, sif.m_valid}, 2'b00);

        // start and abort together in IDLE
        abort = 1'b1;
        pulse_start(0, 0);
        abort = 1'b0;
        chk("abort_beats_start", busy, 1'b0);
        repeat (2) tick();

        // start while busy is ignored
        ready_pct = 50;
        plan_walk(0, 0);
        pulse_start(0, 0);
        repeat (10) tick();
        pulse_start(1, 2);
        wait_done(500, "t6_busy_start_done");
        chk("t6_busy_start_beats", beats_walk, 30);

        // Reset mid-walk while stalled
        ready_pct = 0;
        plan_walk(0, 0);
        nd = n_done;
        pulse_start(0, 0);
        repeat (4) tick();
        chk("t6_stalled_valid", sif.m_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_async_reset");
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        ready_pct = 100;
        repeat (2) tick();
        chk_reset_vals("t6_after_reset");
        chk("t6_no_done", n_done - nd, 0);
        plan_walk(1, 9);
        pulse_start(1, 9);
        wait_done(50, "t6_recover_done");
        chk("t6_recover_beats", beats_walk, 3);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
